pool_row_engine: RTL and testbench
==================================

// Module: pool_row_engine
// PURPOSE
//  Downstream consumer of the PEB psum ping-pong RAM. Once a frame finishes, it reads that frame's psum bank row by row.
//  Each psum goes through ReLU, an arithmetic right shift and saturation to DATA_WIDTH. 2x2 max-pooling is then applied across row pairs.
//  Each pooled row is emitted on a valid/ready stream toward the activation writeback path.
// PARAMETERS
//  DATA_WIDTH  8   output activation width (signed, positive range only after ReLU)
//  LENPSUM     16  psums per RAM row = RAM depth; must be even
//  PSUM_WIDTH  20  signed psum width
//  ADDR_W      C_LOG_2(LENPSUM)  RAM address width
//  SHIFT_W     5   width of the shift control
// PORTS
//  clk             in   1                      clock
//  rst_n           in   1                      asynchronous active-low reset
//  CTRLPOOL_Start  in   1                      pulse: finished bank is ready to pool
//  CTRLPOOL_Shift  in   SHIFT_W                requant right-shift, sampled on accepted Start
//  POOLPEB_EnRd    out  1                      RAM read enable
//  POOLPEB_AddrRd  out  ADDR_W                 RAM read row address
//  PEBPOOL_Dat     in   PSUM_WIDTH*LENPSUM     read data, valid 1 cycle after EnRd; psum i = [i*PSUM_WIDTH +: PSUM_WIDTH]
//  POOLOUT_Vld     out  1                      pooled row valid
//  POOLOUT_Rdy     in   1                      downstream ready
//  POOLOUT_Dat     out  DATA_WIDTH*LENPSUM/2   pooled row; element j = [j*DATA_WIDTH +: DATA_WIDTH]
//  POOLOUT_Last    out  1                      qualifies the last pooled row of the frame
//  POOLCTRL_Busy   out  1                      high whenever not IDLE
//  POOLCTRL_Done   out  1                      1-cycle pulse after the last handshake
// BEHAVIOUR
//  Reset: rst_n is asynchronous, active-low; clk is the clock. All outputs, the row counter k, the shift register and the row register clear to 0; FSM goes to IDLE.
//  FSM:
//   IDLE -> RD0: on Start. Latches Shift; k=0. Start in any other state is ignored.
//   RD0 -> RD1: EnRd=1, AddrRd=2k.
//   RD1 -> CMP: EnRd=1, AddrRd=2k+1. Quantized row 2k is captured into RowReg.
//   CMP -> OUT: combines the quantized row 2k+1 with RowReg and registers POOLOUT_Dat; Vld=1 from the next cycle.
//   OUT: holds Vld and Dat stable until Rdy.
//    - On Vld&Rdy with k<LENPSUM/2-1: k++, go to RD0.
//    - On Vld&Rdy with k==LENPSUM/2-1: Done=1 for the next cycle, go to IDLE.
//  Read pattern: EnRd is high only in RD0/RD1. No reads are issued while OUT is stalled. AddrRd=0 outside reads.
//  Latency: Start accepted at cycle t -> first Vld at t+4. Steady state is 4 cycles per pooled row when Rdy is held high.
//  Quantization q(x):
//   - x<0 -> 0.
//   - Otherwise y = x>>>Shift; q = min(y, 2^(DATA_WIDTH-1)-1).
//   - Shift >= PSUM_WIDTH gives 0.
//  Pooling: out[j] = max(q(r0[2j]), q(r0[2j+1]), q(r1[2j]), q(r1[2j+1])), compared unsigned on DATA_WIDTH bits.
//  Last = Vld & (k==LENPSUM/2-1).
//  Reset mid-frame aborts the frame: no partial Done. The next Start restarts at address 0.
//  Bank select is owned by PEB; this block only drives the read port.
// STRUCTURE
//  Shared include: DATA_WIDTH, LENPSUM, PSUM_WIDTH, C_LOG_2.
//  Sub-module pool_quant: one psum -> ReLU/shift/saturate, purely combinational. Instantiated LENPSUM times by a generate loop; the pair-max logic stays in the top.
//  FSM states are a localparam enum in this file.
// TESTING (LENPSUM=16, PSUM_WIDTH=20, DATA_WIDTH=8)
//  1 Ramp: row r elem i = 16r+i, Shift=1, Rdy=1 -> 8 rows out; row0 elem0 = 17>>1 = 8; row k elem j = ((2k+1)*16+2j+1)>>1 saturated to 127; Done 1 cycle after 8th handshake.
//  2 All psums negative -> every output element 0, 8 rows still emitted, Last only on 8th.
//  3 Psum 0x7FFFF, Shift=0 -> 127; Shift=20 -> 0; Shift=4 on 0x00100 -> 16.
//  4 Rdy low 5 cycles in OUT -> Vld held, Dat bit-stable, EnRd stays 0; resumes with RD0 addr 2k+2 after handshake.
//  5 Start pulsed while Busy -> ignored, address sequence 0..15 unchanged, exactly one Done.
//  6 rst_n low during RD1 of k=3 -> Vld/EnRd/Busy 0 immediately; next Start reads addr 0 first; Shift relatched.

Source files
------------

// File: rtl/pool_row_engine_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_row_engine_pkg : shared sizing defaults and the C_LOG_2 helper
// Rev 1.0
// ---------------------------------------------------------------------------
package pool_row_engine_pkg;

  localparam int POOL_DATA_WIDTH = 8;
  localparam int POOL_LENPSUM    = 16;
  localparam int POOL_PSUM_WIDTH = 20;
  localparam int POOL_SHIFT_W    = 5;

  // Ceiling log2, minimum 1 so a width built from it is never zero
  function automatic int C_LOG_2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_row_engine_quant.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_quant : one psum -> ReLU, arithmetic right shift, saturate to DATA_WIDTH
// Rev 1.0
// ---------------------------------------------------------------------------
module pool_quant
  import pool_row_engine_pkg::*;
#(
  parameter int DATA_WIDTH = POOL_DATA_WIDTH,
  parameter int PSUM_WIDTH = POOL_PSUM_WIDTH,
  parameter int SHIFT_W    = POOL_SHIFT_W
) (
  input  logic signed [PSUM_WIDTH-1:0] i_psum,
  input  logic        [SHIFT_W-1:0]    i_shift,
  output logic        [DATA_WIDTH-1:0] o_q
);

  localparam logic [PSUM_WIDTH-1:0] c_SAT = PSUM_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);

  logic [PSUM_WIDTH-1:0] w_shifted;
  logic                  w_zero;

  // Negative inputs are zeroed first, so a logical shift equals the arithmetic one
  assign w_shifted = $unsigned(i_psum) >> i_shift;
  assign w_zero    = i_psum[PSUM_WIDTH-1] || (32'(i_shift) >= PSUM_WIDTH);

  always_comb begin
    o_q = w_shifted[DATA_WIDTH-1:0];
    if (w_zero) begin
      o_q = '0;
    end else if (w_shifted > c_SAT) begin
      o_q = c_SAT[DATA_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pool_row_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_row_engine : reads a finished psum bank row pair by row pair, quantizes,
// 2x2 max-pools and streams one pooled row per valid/ready handshake.  Rev 1.0
// ---------------------------------------------------------------------------
module pool_row_engine
  import pool_row_engine_pkg::*;
#(
  parameter int DATA_WIDTH = POOL_DATA_WIDTH,
  parameter int LENPSUM    = POOL_LENPSUM,
  parameter int PSUM_WIDTH = POOL_PSUM_WIDTH,
  parameter int ADDR_W     = C_LOG_2(LENPSUM),
  parameter int SHIFT_W    = POOL_SHIFT_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              CTRLPOOL_Start,
  input  logic [SHIFT_W-1:0]                CTRLPOOL_Shift,
  output logic                              POOLPEB_EnRd,
  output logic [ADDR_W-1:0]                 POOLPEB_AddrRd,
  input  logic [PSUM_WIDTH*LENPSUM-1:0]     PEBPOOL_Dat,
  output logic                              POOLOUT_Vld,
  input  logic                              POOLOUT_Rdy,
  output logic [DATA_WIDTH*LENPSUM/2-1:0]   POOLOUT_Dat,
  output logic                              POOLOUT_Last,
  output logic                              POOLCTRL_Busy,
  output logic                              POOLCTRL_Done
);

  localparam int c_NPOOL = LENPSUM / 2;
  localparam int c_K_W   = (ADDR_W > 1) ? ADDR_W - 1 : 1;
  localparam logic [c_K_W-1:0] c_K_LAST = c_K_W'(c_NPOOL - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_CMP  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t                           r_state;
  state_t                           w_next;
  logic   [c_K_W-1:0]               r_k;
  logic   [SHIFT_W-1:0]             r_shift;
  logic   [DATA_WIDTH*LENPSUM-1:0]  r_row;
  logic   [DATA_WIDTH*c_NPOOL-1:0]  r_dat;
  logic                             r_done;
  logic   [DATA_WIDTH*LENPSUM-1:0]  w_q;
  logic   [DATA_WIDTH*c_NPOOL-1:0]  w_pool;
  logic                             w_en_rd;
  logic   [ADDR_W-1:0]              w_addr;
  logic                             w_hs;
  logic                             w_last_row;
  logic                             w_accept;

  assign w_accept   = (r_state == S_IDLE) && CTRLPOOL_Start;
  assign w_hs       = (r_state == S_OUT) && POOLOUT_Rdy;
  assign w_last_row = (r_k == c_K_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_en_rd = 1'b0;
    w_addr  = '0;
    case (r_state)
      S_IDLE: begin
        if (CTRLPOOL_Start) begin
          w_next = S_RD0;
        end
      end
      S_RD0: begin
        w_en_rd = 1'b1;
        w_addr  = ADDR_W'({r_k, 1'b0});
        w_next  = S_RD1;
      end
      S_RD1: begin
        w_en_rd = 1'b1;
        w_addr  = ADDR_W'({r_k, 1'b1});
        w_next  = S_CMP;
      end
      S_CMP: begin
        w_next = S_OUT;
      end
      S_OUT: begin
        if (POOLOUT_Rdy) begin
          w_next = w_last_row ? S_IDLE : S_RD0;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Row 2k is quantized during RD1 (its data arrives one cycle after the RD0 read)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_shift <= '0;
      r_row   <= '0;
      r_dat   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_hs && w_last_row;
      if (w_accept) begin
        r_k     <= '0;
        r_shift <= CTRLPOOL_Shift;
      end else if (w_hs && !w_last_row) begin
        r_k <= r_k + c_K_W'(1);
      end
      if (r_state == S_RD1) begin
        r_row <= w_q;
      end
      if (r_state == S_CMP) begin
        r_dat <= w_pool;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LENPSUM; gi++) begin : g_quant
      pool_quant #(
        .DATA_WIDTH (DATA_WIDTH),
        .PSUM_WIDTH (PSUM_WIDTH),
        .SHIFT_W    (SHIFT_W)
      ) u_quant (
        .i_psum  (PEBPOOL_Dat[gi*PSUM_WIDTH +: PSUM_WIDTH]),
        .i_shift (r_shift),
        .o_q     (w_q[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  genvar gj;
  generate
    for (gj = 0; gj < c_NPOOL; gj++) begin : g_pool
      logic [DATA_WIDTH-1:0] w_a, w_b, w_c, w_d, w_ab, w_cd;
      assign w_a  = w_q[(2*gj)*DATA_WIDTH +: DATA_WIDTH];
      assign w_b  = w_q[(2*gj+1)*DATA_WIDTH +: DATA_WIDTH];
      assign w_c  = r_row[(2*gj)*DATA_WIDTH +: DATA_WIDTH];
      assign w_d  = r_row[(2*gj+1)*DATA_WIDTH +: DATA_WIDTH];
      assign w_ab = (w_a > w_b) ? w_a : w_b;
      assign w_cd = (w_c > w_d) ? w_c : w_d;
      assign w_pool[gj*DATA_WIDTH +: DATA_WIDTH] = (w_ab > w_cd) ? w_ab : w_cd;
    end
  endgenerate

  assign POOLPEB_EnRd   = w_en_rd;
  assign POOLPEB_AddrRd = w_addr;
  assign POOLOUT_Vld    = (r_state == S_OUT);
  assign POOLOUT_Dat    = r_dat;
  assign POOLOUT_Last   = (r_state == S_OUT) && w_last_row;
  assign POOLCTRL_Busy  = (r_state != S_IDLE);
  assign POOLCTRL_Done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pool_row_engine.sv
`timescale 1ns/1ps
`default_nettype none
// tb_pool_row_engine : directed frames through a RAM model; a row-level pooling
// model is checked against the stream every cycle, plus literal anchors.
module tb_pool_row_engine;

  localparam int DW  = 8;
  localparam int LEN = 16;
  localparam int PW  = 20;
  localparam int AW  = 4;
  localparam int SW  = 5;
  localparam int NP  = LEN / 2;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [SW-1:0]     shift = '0;
  logic              en_rd;
  logic [AW-1:0]     addr;
  logic [PW*LEN-1:0] ram_q = '0;
  logic              vld;
  logic              rdy   = 1'b1;
  logic [DW*NP-1:0]  dat;
  logic              last;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  pool_row_engine #(
    .DATA_WIDTH (DW),
    .LENPSUM    (LEN),
    .PSUM_WIDTH (PW),
    .ADDR_W     (AW),
    .SHIFT_W    (SW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .CTRLPOOL_Start (start),
    .CTRLPOOL_Shift (shift),
    .POOLPEB_EnRd   (en_rd),
    .POOLPEB_AddrRd (addr),
    .PEBPOOL_Dat    (ram_q),
    .POOLOUT_Vld    (vld),
    .POOLOUT_Rdy    (rdy),
    .POOLOUT_Dat    (dat),
    .POOLOUT_Last   (last),
    .POOLCTRL_Busy  (busy),
    .POOLCTRL_Done  (done)
  );

  // Psum bank: synchronous read, data one cycle after the enable
  logic signed [PW-1:0] mem [LEN][LEN];
  always_ff @(posedge clk) begin
    if (en_rd) begin
      for (int i = 0; i < LEN; i++) ram_q[i*PW +: PW] <= mem[addr][i];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int qm(input int x, input int sh);
    int y;
    if (x < 0) return 0;
    if (sh >= PW) return 0;
    y = x >>> sh;
    return (y > 127) ? 127 : y;
  endfunction

  int exp_rows [NP][NP];

  task automatic compute_exp(input int sh);
    int m, v;
    for (int k = 0; k < NP; k++) begin
      for (int j = 0; j < NP; j++) begin
        m = 0;
        for (int a = 0; a < 2; a++)
          for (int b = 0; b < 2; b++) begin
            v = qm(int'(mem[2*k+a][2*j+b]), sh);
            if (v > m) m = v;
          end
        exp_rows[k][j] = m;
      end
    end
  endtask

  function automatic logic [63:0] exp_vec(input int k);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < NP; j++) v[j*DW +: DW] = 8'(exp_rows[k][j]);
    return v;
  endfunction

  // Per-cycle comparison against the frame model
  bit          m_active = 0;
  bit          was_active, hs_last;
  bit          exp_done = 0;
  bit          prev_vld = 0, prev_rdy = 0;
  logic [63:0] prev_dat = '0;
  int          row_idx = 0, rd_n = 0, cyc = 0, t_acc = 0, t_hs = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_vld", 64'(vld), 0);
      chk("rst_enrd", 64'(en_rd), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_last", 64'(last), 0);
      m_active = 0; row_idx = 0; rd_n = 0; exp_done = 0;
      prev_vld = 0; prev_rdy = 0;
    end else begin
      was_active = m_active;
      hs_last    = 0;
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(exp_done));
      if (en_rd) begin
        chk("rd_addr", 64'(addr), 64'(rd_n));
        chk("rd_during_out", 64'(vld), 0);
        rd_n++;
      end else begin
        chk("idle_addr", 64'(addr), 0);
      end
      if (prev_vld && !prev_rdy) begin
        chk("hold_vld", 64'(vld), 1);
        chk("hold_dat", dat, prev_dat);
      end
      if (vld) begin
        chk("vld_in_frame", 64'(m_active), 1);
        chk("row_dat", dat, exp_vec(row_idx));
        chk("row_last", 64'(last), 64'(row_idx == NP-1));
        if (!prev_vld) chk("vld_latency", 64'(cyc - ((row_idx == 0) ? t_acc : t_hs)), 4);
        if (rdy) begin
          t_hs = cyc;
          if (row_idx == NP-1) begin
            hs_last = 1; m_active = 0; row_idx = 0;
          end else begin
            row_idx++;
          end
        end
      end else begin
        chk("last_without_vld", 64'(last), 0);
      end
      exp_done = hs_last;
      if (start && !was_active) begin
        m_active = 1; t_acc = cyc; rd_n = 0; row_idx = 0;
        compute_exp(int'(shift));
      end
      prev_vld = vld; prev_rdy = rdy; prev_dat = dat;
    end
  end

  task automatic fill_ramp();
    for (int r = 0; r < LEN; r++) for (int i = 0; i < LEN; i++) mem[r][i] = PW'(16*r + i);
  endtask
  task automatic fill_neg();
    for (int r = 0; r < LEN; r++) for (int i = 0; i < LEN; i++) mem[r][i] = PW'(-(16*r + i + 1));
  endtask
  task automatic fill_const(input int v);
    for (int r = 0; r < LEN; r++) for (int i = 0; i < LEN; i++) mem[r][i] = PW'(v);
  endtask
  task automatic fill_mix();
    for (int r = 0; r < LEN; r++) for (int i = 0; i < LEN; i++)
      mem[r][i] = PW'(((r*7919 + i*613) % 4000) - 1500);
  endtask

  task automatic start_frame(input int sh);
    @(posedge clk); #1;
    start = 1'b1;
    shift = SW'(sh);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_vld(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (vld) begin ok = 1; break; end
    end
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk("done_seen", 64'(got), 1);
  endtask

  task automatic run_frame_lit(input int sh, input int lit0);
    bit ok;
    start_frame(sh);
    wait_vld(ok);
    chk("first_vld_seen", 64'(ok), 1);
    chk("row0_elem0", 64'(dat[7:0]), 64'(lit0));
    wait_done();
  endtask

  initial begin
    bit ok;
    int ndone;
    fill_ramp();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dat", dat, 0);
    chk("rst_addr", 64'(addr), 0);
    rst_n = 1'b1;

    chk("qm_17_s1", 64'(qm(17, 1)), 8);
    chk("qm_neg", 64'(qm(-1, 0)), 0);
    chk("qm_sat_s0", 64'(qm('h7FFFF, 0)), 127);
    chk("qm_s20", 64'(qm('h7FFFF, 20)), 0);
    chk("qm_256_s4", 64'(qm('h100, 4)), 16);
    chk("qm_300_s1", 64'(qm(300, 1)), 127);

    // Ramp, shift 1
    run_frame_lit(1, 8);
    chk("model_r0e0", 64'(exp_rows[0][0]), 8);
    chk("model_r0e7", 64'(exp_rows[0][7]), 15);
    chk("model_r3e2", 64'(exp_rows[3][2]), 58);
    chk("model_r7e7", 64'(exp_rows[7][7]), 127);

    // All negative
    fill_neg();
    run_frame_lit(0, 0);

    // Saturation and shift bounds
    fill_const('h7FFFF);
    run_frame_lit(0, 127);
    run_frame_lit(20, 0);
    fill_const('h100);
    run_frame_lit(4, 16);

    fill_mix();
    run_frame_lit(2, qm(int'(mem[1][1]) > int'(mem[0][0]) ? 0 : 0, 0) + exp_rows[0][0] * 0 +
                  ((qm(int'(mem[0][0]), 2) > qm(int'(mem[0][1]), 2) ? qm(int'(mem[0][0]), 2) : qm(int'(mem[0][1]), 2)) >
                   (qm(int'(mem[1][0]), 2) > qm(int'(mem[1][1]), 2) ? qm(int'(mem[1][0]), 2) : qm(int'(mem[1][1]), 2)) ?
                   (qm(int'(mem[0][0]), 2) > qm(int'(mem[0][1]), 2) ? qm(int'(mem[0][0]), 2) : qm(int'(mem[0][1]), 2)) :
                   (qm(int'(mem[1][0]), 2) > qm(int'(mem[1][1]), 2) ? qm(int'(mem[1][0]), 2) : qm(int'(mem[1][1]), 2))));

    // Back-pressure: row 2 stalled 5 extra cycles, others 1 cycle
    fill_ramp();
    rdy = 1'b0;
    start_frame(1);
    for (int r = 0; r < NP; r++) begin
      wait_vld(ok);
      chk("stall_vld_seen", 64'(ok), 1);
      if (r == 2) begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_vld_held", 64'(vld), 1);
          chk("stall_no_read", 64'(en_rd), 0);
        end
      end
      @(posedge clk); #1 rdy = 1'b1;
      @(posedge clk); #1 rdy = 1'b0;
    end
    rdy = 1'b1;
    chk("stall_done_pulse", 64'(done), 1);

    // Start while busy is ignored
    start_frame(3);
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      start = (i == 3 || i == 12 || i == 25);
      shift = start ? SW'(7) : SW'(3);
      if (done) ndone++;
    end
    start = 1'b0;
    chk("one_done", 64'(ndone), 1);

    // Reset during RD1 of row pair 3
    start_frame(1);
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (en_rd && addr == AW'(7)) begin ok = 1; break; end
    end
    chk("reach_rd1_k3", 64'(ok), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_vld", 64'(vld), 0);
    chk("abort_enrd", 64'(en_rd), 0);
    chk("abort_busy", 64'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame_lit(2, 4);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
`default_nettype wire
